// File: rtl/audio_adc_deserializer.sv
// audio_adc_deserializer
// Read path for a WM8731 ADC stream in left-justified format. BCLK, LRCK and
// DAT are oversampled in the CLOCK_50 domain. Stereo frames are rebuilt,
// parked in a small first-word-fall-through FIFO and popped by user logic.
//
// Optional feature macro: AUDIO_IN_PEAK_EN adds peak_level, a running maximum
// of |left[31:16]| over accepted frames, cleared by a pop or a flush.
//
// FIFO_DEPTH must be a power of two and at least 2; the pointers wrap
// naturally at that width.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_SYNC | discard bits until LRCK goes 1->0 at a BCLK rise
// LEFT      | shifting left-channel bits into left_sr
// RIGHT     | shifting right-channel bits into right_sr; next left
//           | bit completes the frame and requests a push

module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          clear_audio_in_memory,
    input  logic                          read_audio_in,
    output logic                          audio_in_available,
    output logic [31:0]                   left_channel_audio_in,
    output logic [31:0]                   right_channel_audio_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
`ifdef AUDIO_IN_PEAK_EN
    ,
    output logic [15:0]                   peak_level
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DW_CNT = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    // bit order in the sync vectors: [2] BCLK, [1] LRCK, [0] DAT
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] hist_q,  hist_d;

    logic bclk_rise;
    logic lrck_bit;
    logic dat_bit;

    state_t         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0]    left_sr_q, left_sr_d;
    logic [31:0]    right_sr_q, right_sr_d;
    logic           lrck_prev_q, lrck_prev_d;
    logic           push_q, push_d;
    logic [31:0]    push_left_q, push_left_d;
    logic [31:0]    push_right_q, push_right_d;
    logic [31:0]    dat_mask;
    logic [31:0]    first_word;

    logic [FIFO_DEPTH-1:0][63:0] mem_q, mem_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           do_pop;
    logic           do_push;
    logic           fifo_full;

    // Synchroniser chain. Rising edge is judged on sync2 vs history; LRCK and
    // DAT are taken from the history stage so they sit one cycle behind the
    // edge, well inside the half-period they are held stable by the codec.
    always_comb begin
        sync1_d   = {AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT};
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        bclk_rise = sync2_q[2] & ~hist_q[2];
        lrck_bit  = hist_q[1];
        dat_bit   = hist_q[0];
    end

    // Frame assembly: next state, shift registers and push request.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        lrck_prev_d  = lrck_prev_q;
        push_d       = 1'b0;
        push_left_d  = push_left_q;
        push_right_d = push_right_q;
        dat_mask     = dat_bit ? (32'h8000_0000 >> bit_cnt_q) : 32'h0;
        first_word   = {dat_bit, 31'h0};

        if (bclk_rise) begin
            lrck_prev_d = lrck_bit;
            case (state_q)
                WAIT_SYNC: begin
                    if (lrck_prev_q && !lrck_bit) begin
                        left_sr_d = first_word;
                        bit_cnt_d = CW'(1);
                        state_d   = LEFT;
                    end
                end
                LEFT: begin
                    if (!lrck_bit) begin
                        if (bit_cnt_q < DW_CNT) begin
                            left_sr_d = left_sr_q | dat_mask;
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end else begin
                        right_sr_d = first_word;
                        bit_cnt_d  = CW'(1);
                        state_d    = RIGHT;
                    end
                end
                RIGHT: begin
                    if (lrck_bit) begin
                        if (bit_cnt_q < DW_CNT) begin
                            right_sr_d = right_sr_q | dat_mask;
                            bit_cnt_d  = bit_cnt_q + CW'(1);
                        end
                    end else begin
                        // left_sr is untouched while in RIGHT, so it still
                        // holds the finished left word here
                        push_d       = 1'b1;
                        push_left_d  = left_sr_q;
                        push_right_d = right_sr_q;
                        left_sr_d    = first_word;
                        bit_cnt_d    = CW'(1);
                        state_d      = LEFT;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end

        if (clear_audio_in_memory) begin
            state_d   = WAIT_SYNC;
            bit_cnt_d = '0;
            push_d    = 1'b0;
        end
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        do_pop     = read_audio_in && (count_q != '0);
        fifo_full  = (count_q == LW'(FIFO_DEPTH));
        do_push    = push_q && (!fifo_full || do_pop);

        if (clear_audio_in_memory) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {push_left_q, push_right_q};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + LW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - LW'(1);
            end
            if (push_q && !do_push) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and storage registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            state_q      <= WAIT_SYNC;
            bit_cnt_q    <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            lrck_prev_q  <= 1'b0;
            push_q       <= 1'b0;
            push_left_q  <= '0;
            push_right_q <= '0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            lrck_prev_q  <= lrck_prev_d;
            push_q       <= push_d;
            push_left_q  <= push_left_d;
            push_right_q <= push_right_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef AUDIO_IN_PEAK_EN
    logic [15:0] peak_q, peak_d;
    logic [15:0] push_mag;

    function automatic logic [15:0] abs16(input logic [15:0] x);
        if (!x[15]) begin
            return x;
        end else if (x == 16'h8000) begin
            return 16'h7FFF;
        end else begin
            return ~x + 16'd1;
        end
    endfunction

    // Peak tracker; an accepted push wins over a coincident pop.
    always_comb begin
        peak_d   = peak_q;
        push_mag = abs16(push_left_q[31:16]);
        if (clear_audio_in_memory) begin
            peak_d = '0;
        end else if (do_push) begin
            if (do_pop || push_mag > peak_q) begin
                peak_d = push_mag;
            end
        end else if (do_pop) begin
            peak_d = '0;
        end
    end

    // Peak register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

    assign audio_in_available     = (count_q != '0);
    assign left_channel_audio_in  = mem_q[rd_ptr_q][63:32];
    assign right_channel_audio_in = mem_q[rd_ptr_q][31:0];
    assign fifo_level             = count_q;
    assign overflow               = overflow_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Bench for audio_adc_deserializer: drives a left-justified codec stream with
// randomised BCLK timing and checks FIFO contents against a frame-level model.
module tb_audio_adc_deserializer;

    localparam int DEPTH = 4;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        bclk, lrck, dat;
    logic        clr, rd, clr2, rd2;
    logic        avail1, avail2, ovf1, ovf2;
    logic [31:0] left1, right1, left2, right2;
    logic [2:0]  lvl1, lvl2;
`ifdef AUDIO_IN_PEAK_EN
    logic [15:0] peak1, peak2;
`endif

    audio_adc_deserializer #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
`ifdef AUDIO_IN_PEAK_EN
        .peak_level(peak1),
`endif
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
        .clear_audio_in_memory(clr), .read_audio_in(rd),
        .audio_in_available(avail1),
        .left_channel_audio_in(left1), .right_channel_audio_in(right1),
        .fifo_level(lvl1), .overflow(ovf1)
    );

    audio_adc_deserializer #(.DATA_WIDTH(24), .FIFO_DEPTH(DEPTH)) dut24 (
`ifdef AUDIO_IN_PEAK_EN
        .peak_level(peak2),
`endif
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
        .clear_audio_in_memory(clr2), .read_audio_in(rd2),
        .audio_in_available(avail2),
        .left_channel_audio_in(left2), .right_channel_audio_in(right2),
        .fifo_level(lvl2), .overflow(ovf2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // frame-level reference model
    logic [63:0] mq[$];
    logic [63:0] mq2[$];
    bit          m_ovf;
    logic [15:0] m_peak;
    bit          synced, pend_v, seen_right;
    logic [63:0] pend;
    bit          auto_pop;
    int          pops, max_lvl;

    function automatic logic [15:0] mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction

    task automatic model_push(input logic [63:0] f);
        logic [15:0] m;
        if (mq.size() < DEPTH) begin
            mq.push_back(f);
            m = mag(f[63:48]);
            if (m > m_peak) m_peak = m;
        end else begin
            m_ovf = 1'b1;
        end
        if (mq2.size() < DEPTH) mq2.push_back(f & {32'hFFFF_FF00, 32'hFFFF_FF00});
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_peak = '0;
        synced = 1'b0;
        pend_v = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        mq2.delete();
        seen_right = 1'b0;
    endtask

    task automatic tick();
        logic [63:0] exp;
        @(negedge CLOCK_50);
        rd = 1'b0;
        if (auto_pop && avail1) begin
            exp = (mq.size() > 0) ? mq.pop_front() : 64'hx;
            chk_eq("autopop_head", {left1, right1}, exp);
            m_peak = '0;
            pops++;
            rd = 1'b1;
        end
        if (int'(lvl1) > max_lvl) max_lvl = int'(lvl1);
    endtask

    task automatic settle();
        repeat (12) tick();
    endtask

    task automatic send_bit(input logic lv, input logic b, input int half);
        int lo, hi;
        lo = (half != 0) ? half : int'($urandom_range(2, 6));
        hi = (half != 0) ? half : int'($urandom_range(2, 6));
        bclk = 1'b0; lrck = lv; dat = b;
        repeat (lo) tick();
        bclk = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    task automatic reset_checks();
        resetn = 1'b0;
        #1;
        chk_eq("rst_avail", avail1, 0);
        chk_eq("rst_level", lvl1, 0);
        chk_eq("rst_ovf",   ovf1, 0);
        chk_eq("rst_left",  left1, 0);
        chk_eq("rst_right", right1, 0);
`ifdef AUDIO_IN_PEAK_EN
        chk_eq("rst_peak",  peak1, 0);
`endif
        model_reset();
        tick(); tick();
        resetn = 1'b1;
    endtask

    // action: 0 none, 1 flush at right bit 8, 2 reset at right bit 8
    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int action, input int half);
        if (seen_right) begin
            if (pend_v) model_push(pend);
            synced = 1'b1;
        end
        pend   = {l, r};
        pend_v = synced;
        for (int i = 0; i < 64; i++) begin
            if (i == 40 && action == 1) do_clear();
            if (i == 40 && action == 2) reset_checks();
            if (i < 32) send_bit(1'b0, l[31-i], half);
            else        send_bit(1'b1, r[63-i], half);
        end
        seen_right = 1'b1;
    endtask

    task automatic send_rand(input int n);
        for (int k = 0; k < n; k++) send_frame($urandom, $urandom, 0, 0);
    endtask

    task automatic check_state(input string tag);
        chk_eq({tag, "_avail"}, avail1, (mq.size() != 0));
        chk_eq({tag, "_level"}, lvl1, 64'(mq.size()));
        chk_eq({tag, "_ovf"},   ovf1, m_ovf);
        if (mq.size() != 0) chk_eq({tag, "_head"}, {left1, right1}, mq[0]);
`ifdef AUDIO_IN_PEAK_EN
        chk_eq({tag, "_peak"}, peak1, m_peak);
`endif
    endtask

    task automatic pop_check(input string tag);
        chk_eq(tag, {left1, right1}, (mq.size() > 0) ? mq[0] : 64'hx);
        rd = 1'b1;
        tick();
        if (mq.size() > 0) void'(mq.pop_front());
        m_peak = '0;
    endtask

    task automatic pop_check2(input string tag);
        chk_eq(tag, {left2, right2}, (mq2.size() > 0) ? mq2[0] : 64'hx);
        rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
        if (mq2.size() > 0) void'(mq2.pop_front());
    endtask

    logic [31:0] y_l, y_r;

    initial begin
        resetn = 1'b0; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
        clr = 1'b0; rd = 1'b0; clr2 = 1'b0; rd2 = 1'b0;
        auto_pop = 1'b0; pops = 0; max_lvl = 0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        reset_checks();
        tick();

        // first frame after reset is discarded, second lands
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 0, 8);
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 0, 8);
        send_frame($urandom, $urandom, 0, 8);
        settle();
        chk_eq("t1_left",  left1, 32'h1234_5678);
        chk_eq("t1_right", right1, 32'h9ABC_DEF0);
        chk_eq("t1_level", lvl1, 1);
        check_state("t1");
        pop_check("t1_pop");
        tick();
        check_state("t1_after_pop");

        // overflow: six frames into a four-deep FIFO
        do_clear();
        send_rand(7);
        settle();
        chk_eq("ovf_level", lvl1, 4);
        chk_eq("ovf_flag",  ovf1, 1);
        check_state("ovf");
        for (int k = 0; k < 4; k++) pop_check("ovf_pop");
        tick();
        check_state("ovf_drained");
        rd = 1'b1;   // pop on empty must be ignored
        tick();
        tick();
        check_state("pop_empty");

        // streaming with immediate pops
        do_clear();
        auto_pop = 1'b1; pops = 0; max_lvl = 0;
        send_rand(21);
        settle();
        auto_pop = 1'b0;
        tick();
        chk_eq("stream_pops", pops, 20);
        chk_eq("stream_maxlvl_le1", (max_lvl <= 1), 1);
        check_state("stream_end");

        // flush in the middle of a right channel
        send_frame($urandom, $urandom, 1, 0);
        settle();
        chk_eq("clr_level", lvl1, 0);
        chk_eq("clr_ovf",   ovf1, 0);
        y_l = $urandom; y_r = $urandom;
        send_frame(y_l, y_r, 0, 0);
        send_rand(1);
        settle();
        chk_eq("clr_next_frame", {left1, right1}, {y_l, y_r});
        check_state("clr_after");
        pop_check("clr_pop");

        // reset in the middle of a right channel, with frames queued
        send_rand(2);
        send_frame($urandom, $urandom, 2, 0);
        settle();
        check_state("rstmid");
        send_rand(2);
        settle();
        check_state("rstmid_after");
        pop_check("rstmid_pop");

        // 24-bit instance: short words pad the LSBs with zero
        reset_checks();
        tick();
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        send_rand(2);
        settle();
        chk_eq("w24_level", lvl2, 64'(mq2.size()));
        chk_eq("w24_ones",  {left2, right2}, 64'hFFFF_FF00_FFFF_FF00);
        pop_check2("w24_pop0");
        pop_check2("w24_pop1");
        check_state("w32_side");

`ifdef AUDIO_IN_PEAK_EN
        do_clear();
        send_frame({16'h1000, 16'($urandom)}, $urandom, 0, 0);
        send_frame({16'hC000, 16'($urandom)}, $urandom, 0, 0);
        send_frame({16'h2000, 16'($urandom)}, $urandom, 0, 0);
        send_rand(1);
        settle();
        chk_eq("peak_max", peak1, 16'h4000);
        check_state("peak");
        pop_check("peak_pop");
        tick();
        chk_eq("peak_after_pop", peak1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_adc_deserializer.md
Name: audio_adc_deserializer

Overview:
- Codec-facing receiver for the WM8731 ADC serial stream in left-justified format.
- Oversamples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT in the CLOCK_50 domain and rebuilds stereo sample pairs.
- Buffers the pairs in a small FIFO and presents them to user logic through the audio_in_available / read_audio_in pop handshake.
- Sits between the codec pins and sample-consuming logic, as the read path of the audio subsystem.

Parameters:
- DATA_WIDTH, 32: bits captured per channel, MSB-first, left-aligned in the 32-bit outputs.
- FIFO_DEPTH, 4: stereo frames buffered; must be a power of 2, minimum 2.

Ports:
- CLOCK_50  input  1  system clock; all logic in this domain.
- resetn  input  1  asynchronous active-low reset.
- AUD_BCLK  input  1  codec bit clock (asynchronous to CLOCK_50).
- AUD_ADCLRCK  input  1  codec ADC frame clock; 0 = left, 1 = right.
- AUD_ADCDAT  input  1  codec ADC serial data.
- clear_audio_in_memory  input  1  synchronous FIFO flush and overflow clear.
- read_audio_in  input  1  pop request; honoured only while audio_in_available = 1.
- audio_in_available  output  1  FIFO holds at least one frame.
- left_channel_audio_in  output  32  head-of-FIFO left sample.
- right_channel_audio_in  output  32  head-of-FIFO right sample.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of frames held.
- overflow  output  1  sticky; a completed frame was dropped because the FIFO was full.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - All outputs 0, FIFO empty, synchronisers 0, state WAIT_SYNC.
- Input capture:
  - BCLK, LRCK and DAT each pass through a 2-flop synchroniser plus one history flop.
  - BCLK rising edge = sync = 1 and history = 0.
  - All three signals share identical delay, so they stay aligned.
  - DAT and LRCK are sampled on the detected rising edge.
- State machine:
  - WAIT_SYNC: ignore data until the first LRCK 1->0 transition (seen at a BCLK rise), then go to LEFT. This discards any partial frame after reset or flush.
  - LEFT: on each BCLK rise with LRCK = 0:
    - if bit_cnt < DATA_WIDTH, shift DAT into left_sr at bit position 31 - bit_cnt;
    - bit_cnt saturates at DATA_WIDTH; extra bits are ignored.
    - A BCLK rise with LRCK = 1 latches left_sr, clears bit_cnt, captures that first right bit, and goes to RIGHT.
  - RIGHT: same capture into right_sr.
    - A BCLK rise with LRCK = 0 completes the frame: push {left, right}, clear bit_cnt, capture the first left bit, and go to LEFT.
- Short words: unreceived LSBs are 0, and output bits [31-DATA_WIDTH:0] are always 0.
- FIFO push and pop:
  - The push is written on the cycle after the completing BCLK edge; it is visible on audio_in_available one cycle after the write.
  - Full at push: frame dropped, overflow set to 1 (sticky), FIFO contents unchanged.
  - Pop: on a CLOCK_50 edge with read_audio_in = 1 and audio_in_available = 1, the head advances. The outputs show the next entry on the following cycle (first-word-fall-through).
  - read_audio_in while empty: ignored, no pointer change.
  - Push and pop in the same cycle: both take effect and fifo_level is unchanged. Allowed even when full, so no drop.
- clear_audio_in_memory = 1:
  - Pointers, fifo_level and overflow return to 0, and the state returns to WAIT_SYNC.
  - Clear has priority over a simultaneous push or pop.
- Pointers wrap modulo FIFO_DEPTH; a one-bit-wider count distinguishes full from empty.
- Constraint: BCLK period ≥ 4 CLOCK_50 cycles (48 kHz × 64 BCLK ≈ 3.07 MHz, well within margin).

Optional Feature:
- AUDIO_IN_PEAK_EN defined:
  - Adds output peak_level [15:0]: running maximum of |left[31:16]| over pushed frames.
  - Absolute value is computed from two's complement; 0x8000 maps to 0x7FFF.
  - peak_level resets to 0 on a pop and on clear_audio_in_memory.
  - When a push and pop coincide, the value from the pushed frame is kept.
- Not defined: no port, no logic.

Test Plan:
- Reset then 2 frames, L = 0x12345678, R = 0x9ABCDEF0, BCLK = CLOCK_50/16 -> first frame discarded (WAIT_SYNC), second appears; audio_in_available = 1, outputs L = 0x12345678, R = 0x9ABCDEF0, fifo_level = 1.
- 6 frames with no reads, FIFO_DEPTH = 4 -> fifo_level = 4, overflow = 1; popping yields frames 1–4 in order, and frames 5–6 are absent.
- Pop every frame as soon as available, 20 frames -> no overflow, data in order, fifo_level never exceeds 1.
- DATA_WIDTH = 24, frame sends 32 bits of 1 -> outputs 0xFFFFFF00.
- clear_audio_in_memory pulsed mid-right-channel -> fifo_level = 0, overflow = 0; next output frame is the first complete frame after the following LRCK 1->0.
- Reset asserted mid-frame, then released -> outputs 0 immediately; no partial frame is pushed.
- With AUDIO_IN_PEAK_EN defined: left samples 0x1000xxxx, 0xC000xxxx, 0x2000xxxx -> peak_level = 0x4000; after one pop -> 0.
